ula_snapshot_packer: RTL
========================

# ula_snapshot_packer

Transmit-side source for the ULA processing block's `in_stream` AXI4-Stream port. It captures one parallel snapshot (one complex sample per ULA element) at a time from the array front end. It serialises each snapshot into 32-bit stream beats, element 0 first, and marks the end of every frame of SNAPS_PER_FRAME snapshots with TLAST. It provides zero-bubble back-to-back snapshot acceptance, a runtime active-element count, and a sticky overflow flag for snapshots lost while busy.

## Interface
- NUM_ELEM, 4: physical array elements; ≥1.
- SNAPS_PER_FRAME, 16: snapshots per stream frame; ≥1.
- CW = $clog2(NUM_ELEM+1): width of cfg_num_elem (derived, not overridable).

Clocking and reset: one clock; reset is asynchronous and active-high.

- ap_clk  in  1  sole clock; all state updates on rising edge.
- ap_rst  in  1  asynchronous, active-high reset.
- cfg_num_elem  in  CW  active element count. 0 or >NUM_ELEM means NUM_ELEM. Latched only at frame start.
- snap_valid  in  1  snapshot strobe. The producer does not hold it; it is not retried.
- snap_data  in  32*NUM_ELEM  element k at [32k+31:32k]; I in [31:16], Q in [15:0], two's complement.
- snap_ready  out  1  snapshot accepted this cycle if snap_valid=1.
- out_stream_TDATA  out  32  current element word.
- out_stream_TVALID  out  1  beat valid.
- out_stream_TLAST  out  1  last beat of frame.
- out_stream_TREADY  in  1  downstream accept.
- overflow  out  1  sticky; set when a snapshot is dropped.
- frame_count  out  16  completed frames, i.e. TLAST beats accepted; wraps 0xFFFF→0.

## Operation
- State: IDLE / SEND. Registers:
  - shadow (32*NUM_ELEM)
  - elem_idx (0..NUM_ELEM-1)
  - snap_idx (0..SNAPS_PER_FRAME-1)
  - act (latched active count)
  - overflow
  - frame_count
- beat = out_stream_TVALID & out_stream_TREADY.
- last_elem = (elem_idx == act-1).
- last_snap = (snap_idx == SNAPS_PER_FRAME-1).
- snap_ready = !ap_rst & (state==IDLE | (beat & last_elem)). It may depend combinationally on TREADY; the TVALID path does not.
- Accept (snap_valid & snap_ready):
  - shadow ← snap_data.
  - elem_idx ← 0.
  - state ← SEND.
  - If snap_idx==0 at acceptance (frame start), act ← resolved cfg_num_elem.
- SEND:
  - TVALID=1.
  - TDATA = shadow[elem_idx].
  - TLAST = last_elem & last_snap.
- Beat with !last_elem: elem_idx++.
- Beat with last_elem:
  - snap_idx ← last_snap ? 0 : snap_idx+1.
  - frame_count += last_snap.
  - state ← IDLE, unless a snapshot is accepted in the same cycle. In that case stay in SEND with elem_idx←0.
- Drop: snap_valid & !snap_ready sets overflow=1 and discards the snapshot; no other state changes. overflow clears only on ap_rst.
- cfg_num_elem changes mid-frame are ignored until the next frame start.
- Frame length = act × SNAPS_PER_FRAME beats.
- Stream data is bit-exact; no arithmetic on samples.

## Timing
- Reset values:
  - TVALID=0, TLAST=0, TDATA=0.
  - snap_ready=0 while ap_rst=1, 1 from the first edge after release.
  - overflow=0, frame_count=0.
  - state=IDLE; elem_idx, snap_idx, shadow = 0; act=NUM_ELEM.
- Latency: snapshot accepted at edge t → TVALID=1 with element 0 after edge t, i.e. in cycle t+1.
- Throughput:
  - One beat per cycle under TREADY=1.
  - Back-to-back snapshots produce continuous TVALID with no idle cycle, provided snap_valid arrives on the last-element beat cycle.
- AXIS rules:
  - Once TVALID=1, TDATA/TLAST are stable until beat.
  - TVALID never deasserts without a beat except on ap_rst.
- TREADY low stalls elem_idx; snapshots offered during the stall are dropped and flagged.
- act=1 and SNAPS_PER_FRAME=1: every beat carries TLAST; frame_count increments per beat.
- Reset mid-frame:
  - Outputs return to reset values asynchronously.
  - The partial frame is abandoned; no TLAST is emitted for it.
  - The next accepted snapshot starts a new frame with snap_idx=0.

## Test plan
- NUM_ELEM=4, SPF=2, cfg=4, TREADY=1, two snapshots with word k = 0x000k_100k presented on consecutive last-beat cycles → 8 contiguous beats, element order 0..3 per snapshot, TLAST only on beat 8, frame_count=1, overflow=0.
- cfg=2 for frame 1, change cfg to 3 after the first snapshot → frame 1 has 2×2=4 beats. Frame 2, with cfg=3 latched, has 6 beats; TLAST on the 4th and 10th beats.
- TREADY held low for 5 cycles mid-snapshot while snap_valid pulses once → TDATA/TLAST held constant, snapshot dropped, overflow=1 and stays 1; stream resumes at the stalled element.
- Random TREADY (50%) over 100 frames → scoreboard matches every word and TLAST position; frame_count=100.
- ap_rst asserted after beat 3 of frame 1 → TVALID=0 immediately, frame_count=0. After release, a new snapshot yields a full frame from element 0 with correct TLAST.
- NUM_ELEM=1, SPF=1, cfg=0, frame_count preloaded by 65535 frames → TLAST on every beat, and frame_count wraps to 0 on beat 65536.

Source files
------------

// File: rtl/ula_snapshot_packer_if.sv
// AXI4-Stream beat bundle carrying serialised ULA snapshot words.
// Master drives data/valid/last and the sink returns TREADY.
interface ula_snapshot_packer_if;
  logic [31:0] TDATA;
  logic        TVALID;
  logic        TLAST;
  logic        TREADY;

  modport master (output TDATA, output TVALID, output TLAST, input TREADY);
  modport slave  (input TDATA, input TVALID, input TLAST, output TREADY);
endinterface

// File: rtl/ula_snapshot_packer.sv
// Captures one parallel ULA snapshot at a time and serialises it element 0 first
// onto an AXI4-Stream port, closing each frame of SNAPS_PER_FRAME snapshots with TLAST.
module ula_snapshot_packer #(
  parameter int NUM_ELEM        = 4,
  parameter int SNAPS_PER_FRAME = 16,
  localparam int CW             = $clog2(NUM_ELEM + 1)
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst,
  input  logic [CW-1:0]            cfg_num_elem,
  input  logic                     snap_valid,
  input  logic [32*NUM_ELEM-1:0]   snap_data,
  output logic                     snap_ready,
  ula_snapshot_packer_if.master    out_stream,
  output logic                     overflow,
  output logic [15:0]              frame_count
);

  localparam int SW  = (SNAPS_PER_FRAME > 1) ? $clog2(SNAPS_PER_FRAME) : 1;
  localparam int SHW = $clog2(32 * NUM_ELEM);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                  state, state_n;
  logic [32*NUM_ELEM-1:0]  shadow, shadow_n;
  logic [CW-1:0]           elem_idx, elem_idx_n;
  logic [CW-1:0]           act, act_n;
  logic [CW-1:0]           cfg_resolved;
  logic [SW-1:0]           snap_idx, snap_idx_n;
  logic                    overflow_n;
  logic [15:0]             frame_count_n;
  logic                    tvalid;
  logic                    beat;
  logic                    last_elem;
  logic                    last_snap;
  logic                    accept;
  logic [SHW-1:0]          word_base;

  // Zero or an out-of-range count falls back to the full physical array.
  assign cfg_resolved = (int'(cfg_num_elem) == 0 || int'(cfg_num_elem) > NUM_ELEM)
                        ? CW'(NUM_ELEM) : cfg_num_elem;

  assign tvalid     = (state == SEND);
  assign beat       = tvalid && out_stream.TREADY;
  assign last_elem  = (elem_idx == act - CW'(1));
  assign last_snap  = (snap_idx == SW'(SNAPS_PER_FRAME - 1));
  assign snap_ready = !ap_rst && (state == IDLE || (beat && last_elem));
  assign accept     = snap_valid && snap_ready;
  assign word_base  = SHW'(32 * int'(elem_idx));

  assign out_stream.TVALID = tvalid;
  assign out_stream.TDATA  = shadow[word_base +: 32];
  assign out_stream.TLAST  = tvalid && last_elem && last_snap;

  always_comb begin
    state_n       = state;
    shadow_n      = shadow;
    elem_idx_n    = elem_idx;
    snap_idx_n    = snap_idx;
    act_n         = act;
    overflow_n    = overflow;
    frame_count_n = frame_count;

    if (beat) begin
      if (!last_elem) begin
        elem_idx_n = elem_idx + CW'(1);
      end else begin
        snap_idx_n = last_snap ? '0 : snap_idx + SW'(1);
        if (last_snap) frame_count_n = frame_count + 16'd1;
        state_n = IDLE;
      end
    end

    // Frame start is judged after this cycle's beat, so a snapshot taken on
    // the closing TLAST beat still latches the new element count.
    if (accept) begin
      shadow_n   = snap_data;
      elem_idx_n = '0;
      state_n    = SEND;
      if (snap_idx_n == '0) act_n = cfg_resolved;
    end

    if (snap_valid && !snap_ready) overflow_n = 1'b1;
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state       <= IDLE;
      shadow      <= '0;
      elem_idx    <= '0;
      snap_idx    <= '0;
      act         <= CW'(NUM_ELEM);
      overflow    <= 1'b0;
      frame_count <= 16'd0;
    end else begin
      state       <= state_n;
      shadow      <= shadow_n;
      elem_idx    <= elem_idx_n;
      snap_idx    <= snap_idx_n;
      act         <= act_n;
      overflow    <= overflow_n;
      frame_count <= frame_count_n;
    end
  end

endmodule
